// File: rtl/ex_stage_pkg.sv
// Shared definitions for the MIPS execute stage: one-hot aluop bit indices,
// write-enable constants and the divider FSM state encoding.
package ex_stage_pkg;

    localparam int ALUOP_W = 16;

    localparam int ALU_OR   = 0;
    localparam int ALU_AND  = 1;
    localparam int ALU_XOR  = 2;
    localparam int ALU_NOR  = 3;
    localparam int ALU_ADDU = 4;
    localparam int ALU_SUBU = 5;
    localparam int ALU_SLT  = 6;
    localparam int ALU_SLTU = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LINK = 11;
    localparam int ALU_DIV  = 12;
    localparam int ALU_DIVU = 13;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'd0,
        DIV_BY_ZERO = 2'd1,
        DIV_ON      = 2'd2,
        DIV_END     = 2'd3
    } div_state_e;

endpackage

// File: rtl/ex_stage_div.sv
// Iterative restoring divider (one quotient bit per clock) with FREE/BY_ZERO/ON/END
// control FSM; result = {remainder, quotient}, valid while ready is high.
module ex_div
    import ex_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  signed_div,
    input  logic [DATA_W-1:0]     opdata1,
    input  logic [DATA_W-1:0]     opdata2,
    input  logic                  annul,
    output logic [2*DATA_W-1:0]   result,
    output logic                  ready,
    output div_state_e            state_o
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    div_state_e          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_rem;
    logic [DATA_W-1:0]   r_quo;
    logic [DATA_W-1:0]   r_divisor;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [2*DATA_W-1:0] r_result;
    logic                r_ready;

    logic [DATA_W-1:0]   w_abs1;
    logic [DATA_W-1:0]   w_abs2;
    logic [DATA_W:0]     w_shift;
    logic [DATA_W:0]     w_trial;
    logic [DATA_W-1:0]   w_rem_next;
    logic [DATA_W-1:0]   w_quo_next;
    logic [DATA_W-1:0]   w_lo_fix;
    logic [DATA_W-1:0]   w_hi_fix;

    assign w_abs1 = (signed_div && opdata1[DATA_W-1]) ? -opdata1 : opdata1;
    assign w_abs2 = (signed_div && opdata2[DATA_W-1]) ? -opdata2 : opdata2;

    // r_quo starts as the dividend and shifts quotient bits in from the right.
    assign w_shift    = {r_rem, r_quo[DATA_W-1]};
    assign w_trial    = w_shift - {1'b0, r_divisor};
    assign w_rem_next = w_trial[DATA_W] ? w_shift[DATA_W-1:0] : w_trial[DATA_W-1:0];
    assign w_quo_next = {r_quo[DATA_W-2:0], ~w_trial[DATA_W]};
    assign w_lo_fix   = r_neg_q ? -w_quo_next : w_quo_next;
    assign w_hi_fix   = r_neg_r ? -w_rem_next : w_rem_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= DIV_FREE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_result  <= '0;
            r_ready   <= 1'b0;
        end else if (annul) begin
            r_state <= DIV_FREE;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                DIV_FREE: begin
                    r_ready <= 1'b0;
                    if (start) begin
                        if (opdata2 == '0) begin
                            // Raw dividend is parked in r_rem; it becomes the remainder.
                            r_state <= DIV_BY_ZERO;
                            r_rem   <= opdata1;
                        end else begin
                            r_state   <= DIV_ON;
                            r_cnt     <= '0;
                            r_rem     <= '0;
                            r_quo     <= w_abs1;
                            r_divisor <= w_abs2;
                            r_neg_q   <= signed_div & (opdata1[DATA_W-1] ^ opdata2[DATA_W-1]);
                            r_neg_r   <= signed_div & opdata1[DATA_W-1];
                        end
                    end
                end
                DIV_BY_ZERO: begin
                    if (!start) begin
                        r_state <= DIV_FREE;
                    end else begin
                        r_result <= {r_rem, {DATA_W{1'b1}}};
                        r_ready  <= 1'b1;
                        r_state  <= DIV_END;
                    end
                end
                DIV_ON: begin
                    if (!start) begin
                        r_state <= DIV_FREE;
                    end else begin
                        r_rem <= w_rem_next;
                        r_quo <= w_quo_next;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == LAST_STEP) begin
                            r_result <= {w_hi_fix, w_lo_fix};
                            r_ready  <= 1'b1;
                            r_state  <= DIV_END;
                        end
                    end
                end
                DIV_END: begin
                    r_ready <= 1'b0;
                    r_state <= DIV_FREE;
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= DIV_FREE;
                end
            endcase
        end
    end

    assign result  = r_result;
    assign ready   = r_ready;
    assign state_o = r_state;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: single-cycle ALU mux, write-back pass-through and stall request.
// Define EX_DIV_EN to instantiate the iterative DIV/DIVU divider; otherwise DIV/DIVU are NOPs.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ALUOP_W = ex_stage_pkg::ALUOP_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [ALUOP_W-1:0] ex_aluop,
    input  logic [DATA_W-1:0]  ex_reg1,
    input  logic [DATA_W-1:0]  ex_reg2,
    input  logic [4:0]         ex_wd,
    input  logic               ex_wreg,
    input  logic [DATA_W-1:0]  ex_link_address,
    input  logic               ex_is_in_delayslot,
    input  logic [DATA_W-1:0]  ex_inst,
    output logic [4:0]         wd_o,
    output logic               wreg_o,
    output logic [DATA_W-1:0]  wdata_o,
    output logic               hilo_we_o,
    output logic [DATA_W-1:0]  hi_o,
    output logic [DATA_W-1:0]  lo_o,
    output logic               is_in_delayslot_o,
    output logic [DATA_W-1:0]  inst_o,
    output logic               stallreq_o
);

    localparam int SA_W = $clog2(DATA_W);

    logic [SA_W-1:0]   w_sa;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_div_op;
    logic              w_unused;

    assign w_sa     = ex_reg1[SA_W-1:0];
    assign w_div_op = ex_aluop[ALU_DIV] | ex_aluop[ALU_DIVU];
    assign w_unused = &{1'b0, clk, flush, ex_aluop[ALUOP_W-1:ALU_DIVU+1]};

    always_comb begin
        w_alu_res = '0;
        if (ex_aluop[ALU_OR])        w_alu_res = ex_reg1 | ex_reg2;
        else if (ex_aluop[ALU_AND])  w_alu_res = ex_reg1 & ex_reg2;
        else if (ex_aluop[ALU_XOR])  w_alu_res = ex_reg1 ^ ex_reg2;
        else if (ex_aluop[ALU_NOR])  w_alu_res = ~(ex_reg1 | ex_reg2);
        else if (ex_aluop[ALU_ADDU]) w_alu_res = ex_reg1 + ex_reg2;
        else if (ex_aluop[ALU_SUBU]) w_alu_res = ex_reg1 - ex_reg2;
        else if (ex_aluop[ALU_SLT])
            w_alu_res = {{(DATA_W-1){1'b0}}, ($signed(ex_reg1) < $signed(ex_reg2))};
        else if (ex_aluop[ALU_SLTU])
            w_alu_res = {{(DATA_W-1){1'b0}}, (ex_reg1 < ex_reg2)};
        else if (ex_aluop[ALU_SLL])  w_alu_res = ex_reg2 << w_sa;
        else if (ex_aluop[ALU_SRL])  w_alu_res = ex_reg2 >> w_sa;
        else if (ex_aluop[ALU_SRA])  w_alu_res = DATA_W'($signed(ex_reg2) >>> w_sa);
        else if (ex_aluop[ALU_LINK]) w_alu_res = ex_link_address;
    end

    // Every output is forced low while reset is held, including the pass-throughs.
    assign wd_o              = rst ? ex_wd : 5'd0;
    assign wreg_o            = rst & (w_div_op ? WRITE_DISABLE : ex_wreg);
    assign wdata_o           = rst ? w_alu_res : '0;
    assign is_in_delayslot_o = rst & ex_is_in_delayslot;
    assign inst_o            = rst ? ex_inst : '0;

`ifdef EX_DIV_EN
    logic [2*DATA_W-1:0] w_div_result;
    logic                w_div_ready;
    div_state_e          w_div_state;

    ex_div #(.DATA_W(DATA_W)) u_div (
        .clk        (clk),
        .rst        (rst),
        .start      (w_div_op),
        .signed_div (ex_aluop[ALU_DIV]),
        .opdata1    (ex_reg1),
        .opdata2    (ex_reg2),
        .annul      (flush),
        .result     (w_div_result),
        .ready      (w_div_ready),
        .state_o    (w_div_state)
    );

    // A flush landing on the END cycle suppresses the HI/LO write.
    assign hilo_we_o  = rst & w_div_ready & ~flush;
    assign hi_o       = hilo_we_o ? w_div_result[2*DATA_W-1:DATA_W] : '0;
    assign lo_o       = hilo_we_o ? w_div_result[DATA_W-1:0] : '0;
    assign stallreq_o = rst & w_div_op & (w_div_state != DIV_END);
`else
    assign hilo_we_o  = 1'b0;
    assign hi_o       = '0;
    assign lo_o       = '0;
    assign stallreq_o = 1'b0;
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed ALU vectors plus divide, flush and reset scenarios.
// Expectations are queued by the drivers and checked by an independent negedge monitor.
module tb_ex_stage;
    import ex_stage_pkg::*;

`ifdef EX_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        flush;
    logic [15:0] ex_aluop;
    logic [31:0] ex_reg1, ex_reg2, ex_link_address, ex_inst;
    logic [4:0]  ex_wd;
    logic        ex_wreg, ex_is_in_delayslot;
    logic [4:0]  wd_o;
    logic        wreg_o, hilo_we_o, is_in_delayslot_o, stallreq_o;
    logic [31:0] wdata_o, hi_o, lo_o, inst_o;

    typedef struct {
        string       name;
        logic [31:0] wdata;
        logic        wreg;
        logic [4:0]  wd;
        logic [31:0] inst;
        logic        dslot;
    } alu_exp_t;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          stall;
    } div_exp_t;

    alu_exp_t alu_q[$];
    div_exp_t div_q[$];
    int       tests = 0;
    int       fails = 0;
    int       stall_cnt = 0;
    bit       chk_alu = 1'b0;

    ex_stage dut (
        .clk                (clk),
        .rst                (rst),
        .flush              (flush),
        .ex_aluop           (ex_aluop),
        .ex_reg1            (ex_reg1),
        .ex_reg2            (ex_reg2),
        .ex_wd              (ex_wd),
        .ex_wreg            (ex_wreg),
        .ex_link_address    (ex_link_address),
        .ex_is_in_delayslot (ex_is_in_delayslot),
        .ex_inst            (ex_inst),
        .wd_o               (wd_o),
        .wreg_o             (wreg_o),
        .wdata_o            (wdata_o),
        .hilo_we_o          (hilo_we_o),
        .hi_o               (hi_o),
        .lo_o               (lo_o),
        .is_in_delayslot_o  (is_in_delayslot_o),
        .inst_o             (inst_o),
        .stallreq_o         (stallreq_o)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic drive_alu(input string name, input int op, input logic [31:0] r1,
                             input logic [31:0] r2, input logic [31:0] link,
                             input logic [31:0] exp_wdata, input logic exp_wreg);
        alu_exp_t e;
        ex_aluop = '0;
        if (op >= 0) ex_aluop[op] = 1'b1;
        assert ($onehot0(ex_aluop)) else $error("illegal multi-bit aluop");
        ex_reg1            = r1;
        ex_reg2            = r2;
        ex_link_address    = link;
        ex_wd              = 5'($urandom_range(1, 31));
        ex_wreg            = 1'b1;
        ex_inst            = $urandom;
        ex_is_in_delayslot = 1'($urandom_range(0, 1));
        e.name  = name;
        e.wdata = exp_wdata;
        e.wreg  = exp_wreg;
        e.wd    = ex_wd;
        e.inst  = ex_inst;
        e.dslot = ex_is_in_delayslot;
        alu_q.push_back(e);
        chk_alu = 1'b1;
        @(posedge clk);
        #1;
        chk_alu = 1'b0;
    endtask

    task automatic set_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        ex_aluop = '0;
        ex_aluop[sgn ? ALU_DIV : ALU_DIVU] = 1'b1;
        assert ($onehot0(ex_aluop)) else $error("illegal multi-bit aluop");
        ex_reg1 = a;
        ex_reg2 = b;
        ex_wd   = 5'd3;
        ex_wreg = 1'b1;
    endtask

    task automatic run_div(input string name, input bit sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo, input int exp_stall);
`ifdef EX_DIV_EN
        div_exp_t d;
        bit       seen;
        d.name  = name;
        d.hi    = exp_hi;
        d.lo    = exp_lo;
        d.stall = exp_stall;
        div_q.push_back(d);
        set_div(sgn, a, b);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (hilo_we_o) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s timeout: no hilo_we_o within 100 cycles", name);
            void'(div_q.pop_back());
        end
        @(posedge clk);
        #1;
        ex_aluop = '0;
`else
        drive_alu({name, " as nop"}, sgn ? ALU_DIV : ALU_DIVU, a, b, 32'h0, 32'h0, 1'b0);
        if (exp_stall < 0) $display("unused %0h %0h", exp_hi, exp_lo);
`endif
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        alu_exp_t e;
        div_exp_t d;
        if (!rst) begin
            stall_cnt = 0;
        end else begin
            if (chk_alu) begin
                if (alu_q.size() == 0) begin
                    check("alu queue underflow", 32'd1, 32'd0);
                end else begin
                    e = alu_q.pop_front();
                    check({e.name, " wdata"}, wdata_o, e.wdata);
                    check({e.name, " wreg"}, {31'd0, wreg_o}, {31'd0, e.wreg});
                    check({e.name, " wd"}, {27'd0, wd_o}, {27'd0, e.wd});
                    check({e.name, " inst"}, inst_o, e.inst);
                    check({e.name, " dslot"}, {31'd0, is_in_delayslot_o}, {31'd0, e.dslot});
                    check({e.name, " stall"}, {31'd0, stallreq_o}, 32'd0);
                end
            end
            if (hilo_we_o) begin
                if (div_q.size() == 0) begin
                    check("unexpected hilo_we", {31'd0, hilo_we_o}, 32'd0);
                end else begin
                    d = div_q.pop_front();
                    check({d.name, " hi"}, hi_o, d.hi);
                    check({d.name, " lo"}, lo_o, d.lo);
                    check({d.name, " stall cycles"}, stall_cnt, d.stall);
                    check({d.name, " wreg"}, {31'd0, wreg_o}, 32'd0);
                end
                stall_cnt = 0;
            end else if (stallreq_o) begin
                stall_cnt++;
            end else begin
                stall_cnt = 0;
            end
        end
    end

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        ex_aluop = 16'd0;
        ex_aluop[ALU_OR] = 1'b1;
        ex_reg1 = 32'h1234_0000;
        ex_reg2 = 32'h0000_5678;
        ex_wd = 5'd5;
        ex_wreg = 1'b1;
        ex_link_address = 32'h0;
        ex_is_in_delayslot = 1'b1;
        ex_inst = 32'hCAFE_F00D;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset wdata", wdata_o, 32'h0);
        check("reset wd", {27'd0, wd_o}, 32'h0);
        check("reset wreg", {31'd0, wreg_o}, 32'h0);
        check("reset inst", inst_o, 32'h0);
        check("reset hilo_we", {31'd0, hilo_we_o}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        drive_alu("addu wrap", ALU_ADDU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0, 32'h0000_0001, 1'b1);
        drive_alu("slt signed", ALU_SLT, 32'h8000_0000, 32'h0000_0001, 32'h0, 32'h0000_0001, 1'b1);
        drive_alu("sltu unsigned", ALU_SLTU, 32'h8000_0000, 32'h0000_0001, 32'h0, 32'h0000_0000, 1'b1);
        drive_alu("sra sign fill", ALU_SRA, 32'h0000_0004, 32'h8000_0000, 32'h0, 32'hF800_0000, 1'b1);
        drive_alu("srl sa bits only", ALU_SRL, 32'hFFFF_FFE4, 32'h8000_0000, 32'h0, 32'h0800_0000, 1'b1);
        drive_alu("sll 31", ALU_SLL, 32'h0000_001F, 32'h0000_0001, 32'h0, 32'h8000_0000, 1'b1);
        drive_alu("or", ALU_OR, 32'hF0F0_0000, 32'h0000_0F0F, 32'h0, 32'hF0F0_0F0F, 1'b1);
        drive_alu("and", ALU_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0, 32'h0F00_0F00, 1'b1);
        drive_alu("xor", ALU_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0, 32'hF0F0_0F0F, 1'b1);
        drive_alu("nor", ALU_NOR, 32'h0000_0000, 32'hFFFF_0000, 32'h0, 32'h0000_FFFF, 1'b1);
        drive_alu("subu wrap", ALU_SUBU, 32'h0000_0000, 32'h0000_0001, 32'h0, 32'hFFFF_FFFF, 1'b1);
        drive_alu("link", ALU_LINK, 32'h1111_1111, 32'h2222_2222, 32'h0040_0008, 32'h0040_0008, 1'b1);
        drive_alu("nop", -1, 32'h1111_1111, 32'h2222_2222, 32'h0, 32'h0000_0000, 1'b1);

        run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        run_div("divu 100/0", 1'b0, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 2);
        run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33);

        // Flush mid-divide
        set_div(1'b0, 32'd100, 32'd7);
        repeat (5) begin @(posedge clk); #1; end
        check("stall mid divide", {31'd0, stallreq_o}, {31'd0, DIV_EN});
        repeat (5) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        ex_aluop = '0;
        @(negedge clk);
        check("stall after flush", {31'd0, stallreq_o}, 32'd0);
        repeat (40) @(negedge clk);
        @(posedge clk);
        #1;
        run_div("divu 9/3", 1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 33);

        // Asynchronous reset mid-divide
        set_div(1'b0, 32'd1000, 32'd7);
        ex_wd = 5'd9;
        ex_inst = 32'hDEAD_BEEF;
        ex_is_in_delayslot = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        check("rst stall", {31'd0, stallreq_o}, 32'd0);
        check("rst wd", {27'd0, wd_o}, 32'd0);
        check("rst inst", inst_o, 32'd0);
        check("rst dslot", {31'd0, is_in_delayslot_o}, 32'd0);
        check("rst hi", hi_o, 32'd0);
        check("rst lo", lo_o, 32'd0);
        ex_aluop = '0;
        ex_aluop[ALU_OR] = 1'b1;
        #1;
        check("rst or wdata", wdata_o, 32'd0);
        check("rst or wreg", {31'd0, wreg_o}, 32'd0);
        @(posedge clk);
        #1;
        ex_aluop = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_div("divu 10/3", 1'b0, 32'd10, 32'd3, 32'd1, 32'd3, 33);

        repeat (3) @(negedge clk);
        check("div queue drained", div_q.size(), 32'd0);
        check("alu queue drained", alu_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
